pic_interrupt_sequencer: RTL and testbench
==========================================

PIC_INTERRUPT_SEQUENCER -- requirements
Module: pic_interrupt_sequencer

Interface
REQ-001 Ports SHALL be as follows (clock and reset first):
  clk  in  1  system clock; all state updates on posedge clk
  reset  in  1  asynchronous, active-high reset
  ir  in  8  interrupt request lines IR7..IR0, already synchronous to clk
  ltim  in  1  trigger mode: 1 = level, 0 = edge (ICW1 bit 3)
  vector_base  in  5  vector bits T7..T3 (ICW2)
  aeoi  in  1  automatic EOI enable (ICW4 bit 1)
  imr  in  8  interrupt mask (OCW1); 1 = masked
  inta  in  1  one-cycle interrupt-acknowledge strobe
  eoi_stb  in  1  one-cycle EOI command strobe (OCW2)
  eoi_specific  in  1  1 = specific EOI at eoi_level; 0 = non-specific
  eoi_level  in  3  level for specific EOI
  rotate  in  1  qualifies eoi_stb as rotate-on-EOI (OCW2 R bit)
  int_out  out  1  interrupt request to CPU
  vector_out  out  8  vector byte
  vector_valid  out  1  one-cycle qualifier for vector_out
  irr  out  8  interrupt request register
  isr  out  8  in-service register
  spurious  out  1  one-cycle flag: acknowledge found no request
REQ-002 One clock; reset is asynchronous and active-high.

Function
REQ-003 Edge mode: irr[i] SHALL set on a cycle where ir[i]=1 and the previous registered ir[i]=0; level mode: irr[i] SHALL equal the registered ir[i].
REQ-004 irr SHALL latch regardless of imr; imr only gates arbitration.
REQ-005 Priority SHALL be fixed IR0 highest, IR7 lowest, rotated by pointer lowest_prio (reset 7); highest priority is level lowest_prio+1 mod 8.
REQ-006 Candidate = highest-priority bit of irr & ~imr; int_out SHALL be registered, asserting one cycle after the candidate outranks every set isr bit (strictly higher priority; equal or lower blocks).
REQ-007 FSM states IDLE, ACK1, ACK2: IDLE->ACK1 on first inta; ACK1->IDLE on second inta; no timeout.
REQ-008 First inta: latch candidate level, set isr[level], clear irr[level] (edge mode), deassert int_out next cycle.
REQ-009 First inta with no candidate: latch level 7, set no isr bit, assert spurious one cycle.
REQ-010 Second inta: vector_out = {vector_base, level}, vector_valid high for exactly that next cycle; vector_out holds until next vector.
REQ-011 aeoi=1: isr[level] SHALL clear on the second inta cycle (spurious: nothing cleared).
REQ-012 Non-specific EOI clears highest-priority set isr bit; specific EOI clears isr[eoi_level]; EOI with isr==0 is a no-op.
REQ-013 Same-cycle edge on ir[i] and ack clear of irr[i]: set wins.
REQ-014 Same-cycle eoi_stb and first inta: EOI clear applied before new isr bit set.

Reset
REQ-015 reset SHALL force: state IDLE, irr=0, isr=0, ir history=0, lowest_prio=7, int_out=0, vector_out=0, vector_valid=0, spurious=0.
REQ-016 Reset mid-sequence (ACK1/ACK2) SHALL abandon the acknowledge; no vector is emitted afterward.

Configuration
REQ-017 Macro PIC_ROTATE_PRIORITY_EN defined: eoi_stb with rotate=1 sets lowest_prio to the cleared level; with aeoi=1 and rotate held high, the auto-EOI also rotates.
REQ-018 Macro undefined: rotate SHALL be ignored, lowest_prio fixed at 7.

Structure
REQ-019 Package pic_pkg SHALL hold the FSM state enum, NUM_IR=8, LEVEL_W=3.
REQ-020 Sub-module pic_priority_resolver SHALL be combinational: request vector + lowest_prio -> valid + level.

Verification
REQ-021 Edge mode, vector_base=5'h08, ir[3] pulse, inta x2 -> int_out high, isr=8'h08, irr=0, vector_out=8'h43 with one-cycle vector_valid.
REQ-022 ir[5] and ir[2] together, imr=8'h04 -> acknowledge returns level 5; unmasking later raises int_out only after isr[5] cleared by non-specific EOI? No: level 2 outranks, int_out asserts immediately.
REQ-023 isr[1] set, ir[4] requested -> int_out stays low until specific EOI level 1, then rises one cycle later.
REQ-024 inta with irr=0 -> spurious pulse, vector_out={base,3'd7}, isr unchanged.
REQ-025 Macro defined, isr[2] set, eoi_stb+rotate -> lowest_prio=2, next simultaneous ir[1],ir[3] acknowledges level 3; aeoi=1 run -> isr=0 after second inta; reset asserted in ACK1 -> no vector_valid.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared types and constants for the PIC interrupt sequencer.
package pic_pkg;

  localparam int NUM_IR  = 8;
  localparam int LEVEL_W = 3;

  // ST_ACK2 is reserved; the vector is registered directly on the second inta.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK1 = 2'd1,
    ST_ACK2 = 2'd2
  } pic_state_t;

  function automatic logic [NUM_IR-1:0] level_mask(input logic [LEVEL_W-1:0] level);
    return NUM_IR'(1) << level;
  endfunction

  // 0 = highest priority under the current rotation.
  function automatic logic [LEVEL_W-1:0] prio_rank(input logic [LEVEL_W-1:0] level,
                                                   input logic [LEVEL_W-1:0] lowest);
    return level - lowest - LEVEL_W'(1);
  endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Combinational rotating-priority encoder: highest level is lowest_prio+1 mod NUM_IR.
module pic_priority_resolver
  import pic_pkg::*;
(
  input  logic [NUM_IR-1:0]  i_req,
  input  logic [LEVEL_W-1:0] i_lowest_prio,
  output logic               o_valid,
  output logic [LEVEL_W-1:0] o_level
);

  logic [LEVEL_W-1:0] w_idx;

  always_comb begin
    o_valid = 1'b0;
    o_level = i_lowest_prio;
    w_idx   = i_lowest_prio;
    for (int i = 1; i <= NUM_IR; i++) begin
      w_idx = i_lowest_prio + LEVEL_W'(i);
      if (!o_valid && i_req[w_idx]) begin
        o_valid = 1'b1;
        o_level = w_idx;
      end
    end
  end

endmodule

// File: rtl/pic_interrupt_sequencer.sv
// 8259-style interrupt sequencer: request latching, priority arbitration, two-inta acknowledge.
// Define PIC_ROTATE_PRIORITY_EN to enable rotate-on-EOI (and rotate-on-auto-EOI).
module pic_interrupt_sequencer
  import pic_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IR-1:0]  ir,
  input  logic               ltim,
  input  logic [4:0]         vector_base,
  input  logic               aeoi,
  input  logic [NUM_IR-1:0]  imr,
  input  logic               inta,
  input  logic               eoi_stb,
  input  logic               eoi_specific,
  input  logic [LEVEL_W-1:0] eoi_level,
  input  logic               rotate,
  output logic               int_out,
  output logic [7:0]         vector_out,
  output logic               vector_valid,
  output logic [NUM_IR-1:0]  irr,
  output logic [NUM_IR-1:0]  isr,
  output logic               spurious
);

  pic_state_t         r_state, w_state_next;
  logic [NUM_IR-1:0]  r_ir_hist, r_irr, r_isr;
  logic [LEVEL_W-1:0] r_level;
  logic               r_spur_ack, r_int, r_vvalid, r_spur;
  logic [7:0]         r_vector;
  logic [LEVEL_W-1:0] w_lowest_prio;

  logic               w_cand_vld, w_isr_vld, w_cand_ok;
  logic [LEVEL_W-1:0] w_cand_lvl, w_isr_lvl, w_eoi_lvl;
  logic               w_first, w_second, w_eoi_do, w_aeoi_do;
  logic [NUM_IR-1:0]  w_isr_set, w_eoi_clr, w_aeoi_clr, w_irr_next;

  pic_priority_resolver u_cand (
    .i_req         (r_irr & ~imr),
    .i_lowest_prio (w_lowest_prio),
    .o_valid       (w_cand_vld),
    .o_level       (w_cand_lvl)
  );

  pic_priority_resolver u_insvc (
    .i_req         (r_isr),
    .i_lowest_prio (w_lowest_prio),
    .o_valid       (w_isr_vld),
    .o_level       (w_isr_lvl)
  );

  always_comb begin
    w_state_next = r_state;
    w_first      = 1'b0;
    w_second     = 1'b0;
    case (r_state)
      ST_IDLE: if (inta) begin
        w_first      = 1'b1;
        w_state_next = ST_ACK1;
      end
      ST_ACK1: if (inta) begin
        w_second     = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // A candidate only interrupts the CPU when it strictly outranks everything in service.
  always_comb begin
    w_cand_ok  = w_cand_vld &&
                 (!w_isr_vld || (prio_rank(w_cand_lvl, w_lowest_prio) <
                                 prio_rank(w_isr_lvl, w_lowest_prio)));
    w_eoi_do   = eoi_stb && (r_isr != '0);
    w_eoi_lvl  = eoi_specific ? eoi_level : w_isr_lvl;
    w_aeoi_do  = w_second && aeoi && !r_spur_ack;
    w_eoi_clr  = w_eoi_do ? level_mask(w_eoi_lvl) : '0;
    w_aeoi_clr = w_aeoi_do ? level_mask(r_level) : '0;
    w_isr_set  = (w_first && w_cand_vld) ? level_mask(w_cand_lvl) : '0;
    w_irr_next = ltim ? ir : ((r_irr & ~w_isr_set) | (ir & ~r_ir_hist));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_ir_hist  <= '0;
      r_irr      <= '0;
      r_isr      <= '0;
      r_level    <= '0;
      r_spur_ack <= 1'b0;
      r_int      <= 1'b0;
      r_vector   <= '0;
      r_vvalid   <= 1'b0;
      r_spur     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_ir_hist <= ir;
      r_irr     <= w_irr_next;
      r_isr     <= (r_isr & ~w_eoi_clr & ~w_aeoi_clr) | w_isr_set;
      r_int     <= w_cand_ok && !w_first;
      r_vvalid  <= w_second;
      r_spur    <= w_first && !w_cand_vld;
      if (w_first) begin
        r_level    <= w_cand_vld ? w_cand_lvl : LEVEL_W'(NUM_IR - 1);
        r_spur_ack <= !w_cand_vld;
      end
      if (w_second) r_vector <= {vector_base, r_level};
    end
  end

`ifdef PIC_ROTATE_PRIORITY_EN
  logic [LEVEL_W-1:0] r_lowest_prio;

  // Auto-EOI rotation wins if both rotations land in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     r_lowest_prio <= LEVEL_W'(NUM_IR - 1);
    else if (w_aeoi_do && rotate)  r_lowest_prio <= r_level;
    else if (w_eoi_do && rotate)   r_lowest_prio <= w_eoi_lvl;
  end

  assign w_lowest_prio = r_lowest_prio;
`else
  logic w_unused_rotate;

  assign w_unused_rotate = rotate;
  assign w_lowest_prio   = LEVEL_W'(NUM_IR - 1);
`endif

  assign int_out      = r_int;
  assign vector_out   = r_vector;
  assign vector_valid = r_vvalid;
  assign irr          = r_irr;
  assign isr          = r_isr;
  assign spurious     = r_spur;

endmodule

// File: tb/tb_pic_interrupt_sequencer.sv
// Scoreboard bench for pic_interrupt_sequencer: directed scenarios plus randomized traffic
// against a behavioural model; vectors are queued at the second inta and popped by a monitor.
module tb_pic_interrupt_sequencer;

`ifdef PIC_ROTATE_PRIORITY_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] ir;
  logic       ltim;
  logic [4:0] vector_base;
  logic       aeoi;
  logic [7:0] imr;
  logic       inta;
  logic       eoi_stb;
  logic       eoi_specific;
  logic [2:0] eoi_level;
  logic       rotate;
  logic       int_out;
  logic [7:0] vector_out;
  logic       vector_valid;
  logic [7:0] irr;
  logic [7:0] isr;
  logic       spurious;

  pic_interrupt_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .ir           (ir),
    .ltim         (ltim),
    .vector_base  (vector_base),
    .aeoi         (aeoi),
    .imr          (imr),
    .inta         (inta),
    .eoi_stb      (eoi_stb),
    .eoi_specific (eoi_specific),
    .eoi_level    (eoi_level),
    .rotate       (rotate),
    .int_out      (int_out),
    .vector_out   (vector_out),
    .vector_valid (vector_valid),
    .irr          (irr),
    .isr          (isr),
    .spurious     (spurious)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Behavioural model: expected DUT state after the next rising edge.
  bit [7:0]   m_irr, m_isr, m_hist, m_vout;
  bit         m_int, m_vv, m_spur, m_spur_ack;
  int         m_lp, m_state, m_level;
  logic [7:0] exp_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int highest(input bit [7:0] v, input int lp);
    for (int r = 0; r < 8; r++) begin
      if (v[(lp + 1 + r) % 8]) return (lp + 1 + r) % 8;
    end
    return -1;
  endfunction

  function automatic int rank(input int lvl, input int lp);
    return (lvl - lp - 1 + 16) % 8;
  endfunction

  task automatic model_reset();
    m_irr = '0; m_isr = '0; m_hist = '0; m_vout = '0;
    m_int = 0; m_vv = 0; m_spur = 0; m_spur_ack = 0;
    m_lp = 7; m_state = 0; m_level = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    int cand, top, tgt, nlp;
    bit first, second, cand_ok;
    bit [7:0] nirr, nisr;
    cand    = highest(m_irr & ~imr, m_lp);
    top     = highest(m_isr, m_lp);
    first   = (m_state == 0) && inta;
    second  = (m_state == 1) && inta;
    cand_ok = (cand >= 0) && ((top < 0) || (rank(cand, m_lp) < rank(top, m_lp)));
    nlp     = m_lp;
    if (ltim) nirr = ir;
    else begin
      nirr = m_irr;
      if (first && cand >= 0) nirr[cand] = 1'b0;
      nirr = nirr | (ir & ~m_hist);
    end
    nisr = m_isr;
    if (eoi_stb && m_isr != 0) begin
      tgt = eoi_specific ? int'(eoi_level) : top;
      nisr[tgt] = 1'b0;
      if (ROT && rotate) nlp = tgt;
    end
    if (second && aeoi && !m_spur_ack) begin
      nisr[m_level] = 1'b0;
      if (ROT && rotate) nlp = m_level;
    end
    if (first && cand >= 0) nisr[cand] = 1'b1;
    m_vv   = second;
    m_spur = first && (cand < 0);
    if (second) begin
      m_vout = {vector_base, 3'(m_level)};
      exp_q.push_back(m_vout);
      m_state = 0;
    end
    if (first) begin
      m_level    = (cand >= 0) ? cand : 7;
      m_spur_ack = (cand < 0);
      m_state    = 1;
    end
    m_int  = cand_ok && !first;
    m_irr  = nirr;
    m_isr  = nisr;
    m_lp   = nlp;
    m_hist = ir;
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    inta    = 1'b0;
    eoi_stb = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_ir(input logic [7:0] v);
    ir = v; tick();
    ir = '0; tick();
  endtask

  task automatic ack2();
    inta = 1'b1; tick();
    inta = 1'b1; tick();
  endtask

  task automatic eoi_ns();
    eoi_stb = 1'b1; eoi_specific = 1'b0; tick();
  endtask

  // Monitor: per-cycle comparison with the model, vector scoreboard on vector_valid.
  initial begin
    logic [7:0] exp_v;
    forever begin
      @(posedge clk);
      #1;
      check("irr", irr, m_irr);
      check("isr", isr, m_isr);
      check("int_out", int_out, m_int);
      check("vector_valid", vector_valid, m_vv);
      check("spurious", spurious, m_spur);
      check("vector_out_hold", vector_out, m_vout);
      if (vector_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("vector_unexpected", 1, 0);
        end else begin
          exp_v = exp_q.pop_front();
          check("vector_sb", vector_out, exp_v);
        end
      end
    end
  end

  initial begin
    ir = '0; ltim = 1'b0; vector_base = 5'h08; aeoi = 1'b0; imr = '0;
    inta = 1'b0; eoi_stb = 1'b0; eoi_specific = 1'b0; eoi_level = '0; rotate = 1'b0;
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    check("rst_int_out", int_out, 0);
    check("rst_vector_out", vector_out, 0);
    check("rst_isr_irr", {isr, irr}, 0);
    do_reset();

    // Single edge request, full acknowledge.
    pulse_ir(8'h08);
    check("d21_int_out", int_out, 1);
    inta = 1'b1; tick();
    check("d21_isr", isr, 8'h08);
    check("d21_irr", irr, 8'h00);
    check("d21_int_low", int_out, 0);
    inta = 1'b1; tick();
    check("d21_vvalid", vector_valid, 1);
    check("d21_vector", vector_out, 8'h43);
    tick();
    check("d21_vvalid_1cyc", vector_valid, 0);
    check("d21_vector_hold", vector_out, 8'h43);
    eoi_ns();

    // Acknowledge with nothing pending.
    inta = 1'b1; tick();
    check("d24_spurious", spurious, 1);
    inta = 1'b1; tick();
    check("d24_spurious_1cyc", spurious, 0);
    check("d24_vector", vector_out, 8'h47);
    check("d24_isr", isr, 8'h00);

    // Lower-priority request blocked by in-service level 1 until specific EOI.
    pulse_ir(8'h02);
    ack2();
    pulse_ir(8'h10);
    tick();
    check("d23_blocked", int_out, 0);
    eoi_stb = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd1; tick();
    check("d23_eoi_cycle", int_out, 0);
    tick();
    check("d23_rise", int_out, 1);
    ack2();
    check("d23_vector", vector_out, 8'h44);
    eoi_ns();

    // Masked level 2 yields level 5; unmasking lets level 2 preempt at once.
    imr = 8'h04;
    pulse_ir(8'h24);
    ack2();
    check("d22_vector", vector_out, 8'h45);
    imr = 8'h00; tick();
    check("d22_preempt", int_out, 1);
    ack2();
    check("d22_vector2", vector_out, 8'h42);
    eoi_ns();
    eoi_ns();

    // Rotate on EOI, then simultaneous IR1/IR3.
    pulse_ir(8'h04);
    ack2();
    eoi_stb = 1'b1; eoi_specific = 1'b0; rotate = 1'b1; tick();
    rotate = 1'b0;
    pulse_ir(8'h0A);
    ack2();
    check("d25_rotated", vector_out, ROT ? 8'h43 : 8'h41);
    eoi_ns();
    tick();
    ack2();
    eoi_ns();

    // Auto-EOI.
    aeoi = 1'b1;
    pulse_ir(8'h40);
    ack2();
    check("d25_aeoi_isr", isr, 8'h00);
    aeoi = 1'b0;

    // Reset in ACK1 abandons the acknowledge.
    pulse_ir(8'h01);
    inta = 1'b1; tick();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      tick();
      check("d25_no_vector", vector_valid, 0);
    end

    // Randomized traffic, edge then level mode.
    for (int ph = 0; ph < 4; ph++) begin
      ltim        = ph[1];
      aeoi        = ph[0];
      vector_base = 5'($urandom);
      for (int c = 0; c < 700; c++) begin
        for (int b = 0; b < 8; b++) if ($urandom_range(0, 7) == 0) ir[b] = ~ir[b];
        if ($urandom_range(0, 63) == 0) imr = 8'($urandom) & 8'($urandom);
        if (m_state == 0) inta = m_int ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 99) == 0);
        else              inta = ($urandom_range(0, 2) == 0);
        eoi_stb      = ($urandom_range(0, 11) == 0);
        eoi_specific = 1'($urandom);
        eoi_level    = 3'($urandom);
        rotate       = 1'($urandom);
        if ($urandom_range(0, 499) == 0) do_reset();
        else tick();
      end
      do_reset();
    end

    tick();
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
